// File: rtl/cpu_run_ctrl_if.sv
// Bus bundle between the run controller and its host: run control, CPU write tap,
// CPU control outputs, trace read port and status.
interface cpu_run_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    logic                     i_start;
    logic                     i_abort;
    logic [CNT_W-1:0]         i_run_cycles;
    logic                     i_wr_valid;
    logic [ADDR_W-1:0]        i_wr_add;
    logic [DATA_W-1:0]        i_wr_data;
    logic                     o_cpu_reset_n;
    logic                     o_cpu_stop;
    logic                     i_rd_en;
    logic [$clog2(DEPTH)-1:0] i_rd_idx;
    logic [ADDR_W-1:0]        o_rd_add;
    logic [DATA_W-1:0]        o_rd_data;
    logic                     o_rd_valid;
    logic [$clog2(DEPTH):0]   o_trace_count;
    logic                     o_overflow;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_aborted;

    modport slave (
        input  i_start, i_abort, i_run_cycles, i_wr_valid, i_wr_add, i_wr_data,
               i_rd_en, i_rd_idx,
        output o_cpu_reset_n, o_cpu_stop, o_rd_add, o_rd_data, o_rd_valid,
               o_trace_count, o_overflow, o_busy, o_done, o_aborted
    );

    modport master (
        output i_start, i_abort, i_run_cycles, i_wr_valid, i_wr_add, i_wr_data,
               i_rd_en, i_rd_idx,
        input  o_cpu_reset_n, o_cpu_stop, o_rd_add, o_rd_data, o_rd_valid,
               o_trace_count, o_overflow, o_busy, o_done, o_aborted
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the FDE CPU: reset/hold/run sequencing with a bounded run
// window, plus a DEPTH-entry trace of CPU writes readable by index.
module cpu_run_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16,
    parameter int RST_CYC  = 2,
    parameter int HOLD_CYC = 3,
    parameter int CAP_MODE = 0,
    parameter int WRAP     = 0
) (
    input logic          i_clk,
    input logic          i_reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_HOLD, S_RUN, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, run_len;
    logic               start_go, abort_go;
    logic               reset_n_nx, stop_nx, busy_nx, done_nx;

    logic               cpu_reset_n, cpu_stop, busy, done, aborted;
    logic [IDX_W-1:0]   wr_ptr, old_ptr, rd_slot;
    logic [IDX_W:0]     count;
    logic               overflow, full, cap_hit, mem_we;
    logic [ENT_W-1:0]   entry, prev, mem [DEPTH];
    logic [ADDR_W-1:0]  rd_add;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_go = 1'b0;
        abort_go = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.i_start) begin
                    start_go = 1'b1;
                    state_nx = S_RESET;
                end
            end
            S_RESET: begin
                if (bus.i_abort) begin
                    abort_go = 1'b1;
                    state_nx = S_DONE;
                end else if (cnt == CNT_W'(RST_CYC - 1)) begin
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.i_abort) begin
                    abort_go = 1'b1;
                    state_nx = S_DONE;
                end else if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.i_abort) begin
                    abort_go = 1'b1;
                    state_nx = S_DONE;
                end else if (run_len != '0 && cnt == run_len - CNT_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Outputs are registered from the next state so they track the state without lag.
        reset_n_nx = !(state_nx == S_IDLE || state_nx == S_RESET);
        stop_nx    = (state_nx != S_RUN);
        busy_nx    = (state_nx == S_RESET || state_nx == S_HOLD || state_nx == S_RUN);
        done_nx    = (state_nx == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt         <= '0;
            run_len     <= '0;
            cpu_reset_n <= 1'b0;
            cpu_stop    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            cnt         <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
            if (start_go) run_len <= bus.i_run_cycles;
            cpu_reset_n <= reset_n_nx;
            cpu_stop    <= stop_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            if (start_go)      aborted <= 1'b0;
            else if (abort_go) aborted <= 1'b1;
        end
    end

    always_comb begin
        entry   = {bus.i_wr_add, bus.i_wr_data};
        full    = (count == (IDX_W + 1)'(DEPTH));
        cap_hit = (state == S_RUN) && ((CAP_MODE == 0) ? bus.i_wr_valid : (entry != prev));
        mem_we  = cap_hit && (!full || WRAP != 0);
        rd_slot = old_ptr + bus.i_rd_idx;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || start_go) begin
            wr_ptr   <= '0;
            old_ptr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (cap_hit) begin
            if (!full) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
                count  <= count + (IDX_W + 1)'(1);
            end else begin
                overflow <= 1'b1;
                if (WRAP != 0) begin
                    wr_ptr  <= wr_ptr + IDX_W'(1);
                    old_ptr <= old_ptr + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)                   prev <= '0;
        else if (state == S_HOLD)      prev <= entry;
        else if (cap_hit)              prev <= entry;
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_add   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (bus.i_rd_en) begin
            if ({1'b0, bus.i_rd_idx} < count) begin
                {rd_add, rd_data} <= mem[rd_slot];
                rd_valid          <= 1'b1;
            end else begin
                rd_add   <= '0;
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

    assign bus.o_cpu_reset_n = cpu_reset_n;
    assign bus.o_cpu_stop    = cpu_stop;
    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_aborted     = aborted;
    assign bus.o_trace_count = count;
    assign bus.o_overflow    = overflow;
    assign bus.o_rd_add      = rd_add;
    assign bus.o_rd_data     = rd_data;
    assign bus.o_rd_valid    = rd_valid;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances (CAP_MODE=0/WRAP=0,
// CAP_MODE=1, WRAP=1) share one stimulus stream.
module tb_cpu_run_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, abort, wr_valid, rd_en;
    logic [15:0] run_cycles;
    logic [3:0]  wr_add, rd_idx;
    logic [7:0]  wr_data;
    int          vec = 0;
    int          miss = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CNT_W(16)) if0 ();
    cpu_run_ctrl_if #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CNT_W(16)) if1 ();
    cpu_run_ctrl_if #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CNT_W(16)) if2 ();

    assign if0.i_start = start;      assign if1.i_start = start;      assign if2.i_start = start;
    assign if0.i_abort = abort;      assign if1.i_abort = abort;      assign if2.i_abort = abort;
    assign if0.i_run_cycles = run_cycles;
    assign if1.i_run_cycles = run_cycles;
    assign if2.i_run_cycles = run_cycles;
    assign if0.i_wr_valid = wr_valid; assign if1.i_wr_valid = wr_valid; assign if2.i_wr_valid = wr_valid;
    assign if0.i_wr_add = wr_add;    assign if1.i_wr_add = wr_add;    assign if2.i_wr_add = wr_add;
    assign if0.i_wr_data = wr_data;  assign if1.i_wr_data = wr_data;  assign if2.i_wr_data = wr_data;
    assign if0.i_rd_en = rd_en;      assign if1.i_rd_en = rd_en;      assign if2.i_rd_en = rd_en;
    assign if0.i_rd_idx = rd_idx;    assign if1.i_rd_idx = rd_idx;    assign if2.i_rd_idx = rd_idx;

    cpu_run_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CNT_W(16), .RST_CYC(2), .HOLD_CYC(3),
                   .CAP_MODE(0), .WRAP(0)) u0 (.i_clk(clk), .i_reset(rst), .bus(if0.slave));
    cpu_run_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CNT_W(16), .RST_CYC(2), .HOLD_CYC(3),
                   .CAP_MODE(1), .WRAP(0)) u1 (.i_clk(clk), .i_reset(rst), .bus(if1.slave));
    cpu_run_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CNT_W(16), .RST_CYC(2), .HOLD_CYC(3),
                   .CAP_MODE(0), .WRAP(1)) u2 (.i_clk(clk), .i_reset(rst), .bus(if2.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        run_cycles = n;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!if0.o_done && n < budget) begin
            step();
            n++;
        end
        vec++;
        if (if0.o_done !== 1'b1) begin
            miss++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", if0.o_done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
        run_cycles = '0; wr_add = '0; wr_data = '0; rd_idx = '0;
        step();
        step();
        rst = 1'b0;
        vec++;
        // {reset_n, stop, busy, done, aborted, overflow, rd_valid, count, rd_add, rd_data}
        if ({if0.o_cpu_reset_n, if0.o_cpu_stop, if0.o_busy, if0.o_done, if0.o_aborted,
             if0.o_overflow, if0.o_rd_valid, if0.o_trace_count, if0.o_rd_add, if0.o_rd_data}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 8'd0}) begin
            miss++;
            $display("FAIL reset_state: rn=%b st=%b bz=%b dn=%b ab=%b ov=%b rv=%b cnt=%0d add=%h data=%h, required 0 1 0 0 0 0 0 0 0 00",
                     if0.o_cpu_reset_n, if0.o_cpu_stop, if0.o_busy, if0.o_done, if0.o_aborted,
                     if0.o_overflow, if0.o_rd_valid, if0.o_trace_count, if0.o_rd_add, if0.o_rd_data);
        end
    endtask

    task automatic test_run_timing();
        logic [3:0] exp;
        do_start(16'd10);
        for (int k = 0; k < 16; k++) begin
            // {reset_n, stop, busy, done}
            if (k < 2)       exp = 4'b0110;
            else if (k < 5)  exp = 4'b1110;
            else if (k < 15) exp = 4'b1010;
            else             exp = 4'b1101;
            vec++;
            if ({if0.o_cpu_reset_n, if0.o_cpu_stop, if0.o_busy, if0.o_done} !== exp) begin
                miss++;
                $display("FAIL run_timing cycle %0d: {rn,st,bz,dn}=%b, required %b", k,
                         {if0.o_cpu_reset_n, if0.o_cpu_stop, if0.o_busy, if0.o_done}, exp);
            end
            if (k < 15) step();
        end
    endtask

    task automatic test_capture();
        do_start(16'd10);
        repeat (5) step();
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1'b1;
            wr_add = 4'(i);
            wr_data = 8'h0F + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        wait_done(40);
        vec++;
        if (if0.o_trace_count !== 5'd5) begin
            miss++;
            $display("FAIL cap_count: count=%0d, required 5", if0.o_trace_count);
        end
        rd_en = 1'b1; rd_idx = 4'd2;
        step();
        vec++;
        if ({if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data} !== {1'b1, 4'd3, 8'h12}) begin
            miss++;
            $display("FAIL cap_idx2: v=%b add=%h data=%h, required 1 3 12",
                     if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data);
        end
        rd_idx = 4'd7;
        step();
        vec++;
        if ({if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data} !== {1'b0, 4'd0, 8'h00}) begin
            miss++;
            $display("FAIL cap_idx7: v=%b add=%h data=%h, required 0 0 00",
                     if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data);
        end
        rd_idx = 4'd4;
        step();
        rd_en = 1'b0; rd_idx = 4'd0;
        step();
        vec++;
        if ({if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data} !== {1'b0, 4'd5, 8'h14}) begin
            miss++;
            $display("FAIL cap_rd_hold: v=%b add=%h data=%h, required 0 5 14",
                     if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data);
        end
    endtask

    task automatic test_cap_mode1();
        wr_valid = 1'b0; wr_add = 4'd2; wr_data = 8'h55;
        do_start(16'd10);
        repeat (5) step();
        repeat (3) step();
        wr_add = 4'd3; wr_data = 8'h66;
        repeat (4) step();
        wait_done(40);
        vec++;
        if ({if1.o_trace_count, if0.o_trace_count} !== {5'd1, 5'd0}) begin
            miss++;
            $display("FAIL cap_mode1_count: mode1=%0d mode0=%0d, required 1 0",
                     if1.o_trace_count, if0.o_trace_count);
        end
        rd_en = 1'b1; rd_idx = 4'd0;
        step();
        rd_en = 1'b0;
        vec++;
        if ({if1.o_rd_valid, if1.o_rd_add, if1.o_rd_data} !== {1'b1, 4'd3, 8'h66}) begin
            miss++;
            $display("FAIL cap_mode1_entry: v=%b add=%h data=%h, required 1 3 66",
                     if1.o_rd_valid, if1.o_rd_add, if1.o_rd_data);
        end
    endtask

    task automatic test_full();
        wr_add = '0; wr_data = '0;
        do_start(16'd30);
        repeat (5) step();
        for (int i = 1; i <= 20; i++) begin
            wr_valid = 1'b1;
            wr_add = 4'(i);
            wr_data = 8'(i);
            step();
        end
        wr_valid = 1'b0;
        wait_done(40);
        vec++;
        if ({if0.o_trace_count, if0.o_overflow, if2.o_trace_count, if2.o_overflow}
            !== {5'd16, 1'b1, 5'd16, 1'b1}) begin
            miss++;
            $display("FAIL full_status: w0 cnt=%0d ov=%b w1 cnt=%0d ov=%b, required 16 1 16 1",
                     if0.o_trace_count, if0.o_overflow, if2.o_trace_count, if2.o_overflow);
        end
        rd_en = 1'b1; rd_idx = 4'd15;
        step();
        vec++;
        if ({if0.o_rd_add, if0.o_rd_data, if2.o_rd_add, if2.o_rd_data}
            !== {4'd0, 8'd16, 4'd4, 8'd20}) begin
            miss++;
            $display("FAIL full_idx15: w0 add=%h data=%0d w1 add=%h data=%0d, required 0 16 4 20",
                     if0.o_rd_add, if0.o_rd_data, if2.o_rd_add, if2.o_rd_data);
        end
        rd_idx = 4'd0;
        step();
        rd_en = 1'b0;
        vec++;
        if ({if0.o_rd_data, if2.o_rd_add, if2.o_rd_data} !== {8'd1, 4'd5, 8'd5}) begin
            miss++;
            $display("FAIL full_idx0: w0 data=%0d w1 add=%h data=%0d, required 1 5 5",
                     if0.o_rd_data, if2.o_rd_add, if2.o_rd_data);
        end
    endtask

    task automatic test_abort();
        do_start(16'd10);
        repeat (5) step();
        wr_valid = 1'b1; wr_add = 4'd7; wr_data = 8'hA7;
        step();
        wr_add = 4'd8; wr_data = 8'hA8;
        step();
        wr_valid = 1'b0; start = 1'b1; run_cycles = 16'd1;
        step();
        start = 1'b0;
        vec++;
        if ({if0.o_busy, if0.o_cpu_stop, if0.o_trace_count} !== {1'b1, 1'b0, 5'd2}) begin
            miss++;
            $display("FAIL start_in_run: bz=%b st=%b cnt=%0d, required 1 0 2",
                     if0.o_busy, if0.o_cpu_stop, if0.o_trace_count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vec++;
        if ({if0.o_cpu_stop, if0.o_done, if0.o_aborted, if0.o_busy, if0.o_trace_count}
            !== {1'b1, 1'b1, 1'b1, 1'b0, 5'd2}) begin
            miss++;
            $display("FAIL abort_run: st=%b dn=%b ab=%b bz=%b cnt=%0d, required 1 1 1 0 2",
                     if0.o_cpu_stop, if0.o_done, if0.o_aborted, if0.o_busy, if0.o_trace_count);
        end
        rd_en = 1'b1; rd_idx = 4'd1;
        step();
        rd_en = 1'b0;
        vec++;
        if ({if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data} !== {1'b1, 4'd8, 8'hA8}) begin
            miss++;
            $display("FAIL abort_trace: v=%b add=%h data=%h, required 1 8 a8",
                     if0.o_rd_valid, if0.o_rd_add, if0.o_rd_data);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vec++;
        if ({if0.o_done, if0.o_aborted, if0.o_busy} !== {1'b1, 1'b1, 1'b0}) begin
            miss++;
            $display("FAIL abort_in_done: dn=%b ab=%b bz=%b, required 1 1 0",
                     if0.o_done, if0.o_aborted, if0.o_busy);
        end
        do_start(16'd0);
        vec++;
        if ({if0.o_aborted, if0.o_trace_count, if0.o_busy} !== {1'b0, 5'd0, 1'b1}) begin
            miss++;
            $display("FAIL restart_clears: ab=%b cnt=%0d bz=%b, required 0 0 1",
                     if0.o_aborted, if0.o_trace_count, if0.o_busy);
        end
        repeat (30) step();
        vec++;
        if ({if0.o_cpu_stop, if0.o_busy, if0.o_done} !== {1'b0, 1'b1, 1'b0}) begin
            miss++;
            $display("FAIL unbounded_run: st=%b bz=%b dn=%b, required 0 1 0",
                     if0.o_cpu_stop, if0.o_busy, if0.o_done);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vec++;
        if ({if0.o_cpu_stop, if0.o_done, if0.o_aborted} !== {1'b1, 1'b1, 1'b1}) begin
            miss++;
            $display("FAIL unbounded_abort: st=%b dn=%b ab=%b, required 1 1 1",
                     if0.o_cpu_stop, if0.o_done, if0.o_aborted);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(16'd10);
        repeat (5) step();
        wr_valid = 1'b1; wr_add = 4'd1; wr_data = 8'h01;
        step();
        step();
        wr_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vec++;
        if ({if0.o_cpu_reset_n, if0.o_cpu_stop, if0.o_trace_count, if0.o_busy, if0.o_done}
            !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
            miss++;
            $display("FAIL reset_mid_run: rn=%b st=%b cnt=%0d bz=%b dn=%b, required 0 1 0 0 0",
                     if0.o_cpu_reset_n, if0.o_cpu_stop, if0.o_trace_count, if0.o_busy, if0.o_done);
        end
        step();
        vec++;
        if ({if0.o_busy, if0.o_cpu_reset_n} !== {1'b0, 1'b0}) begin
            miss++;
            $display("FAIL reset_stays_idle: bz=%b rn=%b, required 0 0", if0.o_busy, if0.o_cpu_reset_n);
        end
    endtask

    initial begin
        test_reset();
        test_run_timing();
        test_capture();
        test_cap_mode1();
        test_full();
        test_abort();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
